// File: rtl/demux_pkg.sv
// Shared definitions for the registered active-low select strobe/scan block.
package demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Widest dwell field the helper supports; callers zero-extend into it.
  localparam int MAX_LEN_W = 16;

  // A programmed length of zero still dwells for one cycle.
  function automatic logic [MAX_LEN_W-1:0] dwell_len(input logic [MAX_LEN_W-1:0] len);
    return (len == '0) ? MAX_LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/demux_strobe_if.sv
// Request/select bundle between the sequencer and the strobe block.
interface demux_strobe_if #(
  parameter int SEL_W = 3,
  parameter int LEN_W = 4
);

  logic                    req;
  logic [SEL_W-1:0]        sel;
  logic [LEN_W-1:0]        len;
  logic                    scan;
  logic [(1<<SEL_W)-1:0]   out_n;
  logic                    busy;
  logic                    done;

  modport master (output req, sel, len, scan, input out_n, busy, done);
  modport slave  (input req, sel, len, scan, output out_n, busy, done);

endinterface

// File: rtl/demux_n.sv
// Combinational active-low index decoder; disabled means every line high.
module demux_n #(
  parameter int SEL_W = 3
) (
  input  logic                  en,
  input  logic [SEL_W-1:0]      idx,
  output logic [(1<<SEL_W)-1:0] y
);

  always_comb begin
    y = '1;
    if (en) y[idx] = 1'b0;
  end

endmodule

// File: rtl/demux_strobe.sv
// Drives one active-low select for a programmed dwell (strobe) or walks all
// lines in turn (scan). Every output comes straight from a flop.
module demux_strobe
  import demux_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int LEN_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  demux_strobe_if.slave   bus
);

  localparam int N = 1 << SEL_W;

  state_t                 state;
  logic [SEL_W-1:0]       idx;
  logic [SEL_W-1:0]       idx_next;
  logic [LEN_W-1:0]       cnt;
  logic [LEN_W-1:0]       reload;
  logic                   scan_mode;
  logic [N-1:0]           out_q;
  logic                   busy_q;
  logic                   done_q;

  logic [MAX_LEN_W-1:0]   len_ext;
  logic [MAX_LEN_W-1:0]   dwell;
  logic [LEN_W-1:0]       accept_cnt;
  logic                   dwell_end;
  logic                   advance_scan;
  logic                   gap_last;

  logic                   dec_en;
  logic [SEL_W-1:0]       dec_idx;
  logic [N-1:0]           dec_y;

  assign len_ext      = MAX_LEN_W'(bus.len);
  assign dwell        = dwell_len(len_ext);
  assign accept_cnt   = LEN_W'(dwell - MAX_LEN_W'(1));
  assign idx_next     = idx + SEL_W'(1);
  assign dwell_end    = (state == ST_DWELL) && (cnt == '0);
  assign advance_scan = dwell_end && scan_mode && bus.req;

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      localparam int GW = $clog2(GAP_CYCLES + 1);
      logic [GW-1:0] gap_cnt;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          gap_cnt <= '0;
        end else if (advance_scan) begin
          gap_cnt <= GW'(GAP_CYCLES - 1);
        end else if (state == ST_GAP && gap_cnt != '0) begin
          gap_cnt <= gap_cnt - GW'(1);
        end
      end

      assign gap_last = (gap_cnt == '0);
    end else begin : g_nogap
      assign gap_last = 1'b1;
    end
  endgenerate

  // Selects which line (if any) is low in the cycle after this edge.
  always_comb begin
    dec_en  = 1'b0;
    dec_idx = idx;
    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          dec_en  = 1'b1;
          dec_idx = bus.sel;
        end
      end
      ST_DWELL: begin
        if (cnt != '0) begin
          dec_en = 1'b1;
        end else if (advance_scan && GAP_CYCLES == 0) begin
          dec_en  = 1'b1;
          dec_idx = idx_next;
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          dec_en  = 1'b1;
          dec_idx = idx_next;
        end
      end
      default: ;
    endcase
  end

  demux_n #(.SEL_W(SEL_W)) u_dec (
    .en  (dec_en),
    .idx (dec_idx),
    .y   (dec_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      reload    <= '0;
      scan_mode <= 1'b0;
      out_q     <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      out_q  <= dec_y;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            idx       <= bus.sel;
            cnt       <= accept_cnt;
            reload    <= accept_cnt;
            scan_mode <= bus.scan;
            busy_q    <= 1'b1;
            state     <= ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (cnt != '0) begin
            cnt <= cnt - LEN_W'(1);
          end else if (advance_scan) begin
            if (GAP_CYCLES == 0) begin
              idx <= idx_next;
              cnt <= reload;
            end else begin
              state <= ST_GAP;
            end
          end else begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_last) begin
            idx   <= idx_next;
            cnt   <= reload;
            state <= ST_DWELL;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_n = out_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_demux_strobe.sv
// Directed bench for demux_strobe: default build plus SEL_W=1 and SEL_W=4 gapless scans.
module tb_demux_strobe;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  demux_strobe_if #(.SEL_W(3), .LEN_W(4)) bus ();
  demux_strobe_if #(.SEL_W(1), .LEN_W(4)) b1 ();
  demux_strobe_if #(.SEL_W(4), .LEN_W(4)) b4 ();

  demux_strobe #(.SEL_W(3), .LEN_W(4), .GAP_CYCLES(1)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus)
  );
  demux_strobe #(.SEL_W(1), .LEN_W(4), .GAP_CYCLES(0)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (b1)
  );
  demux_strobe #(.SEL_W(4), .LEN_W(4), .GAP_CYCLES(0)) dut4 (
    .clk (clk), .rst_n (rst_n), .bus (b4)
  );

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] exp_out,
                             input logic exp_busy, input logic exp_done);
    checkVal({tag, "_out"},  16'(bus.out_n), 16'(exp_out));
    checkVal({tag, "_busy"}, 16'(bus.busy),  16'(exp_busy));
    checkVal({tag, "_done"}, 16'(bus.done),  16'(exp_done));
  endtask

  task automatic applyStimulus(input logic req, input logic [2:0] sel,
                               input logic [3:0] len, input logic scan);
    bus.req  = req;
    bus.sel  = sel;
    bus.len  = len;
    bus.scan = scan;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // At most one line low, and done only while every line is high.
  always @(negedge clk) begin
    checkVal("inv_main", 16'($countones(~bus.out_n) <= 1), 16'd1);
    checkVal("inv_d1",   16'($countones(~b1.out_n) <= 1),  16'd1);
    checkVal("inv_d4",   16'($countones(~b4.out_n) <= 1),  16'd1);
    checkVal("done_hi",  16'(!bus.done || (&bus.out_n)),   16'd1);
  end

  logic [7:0] scan_exp [11];

  initial begin
    scan_exp = '{8'hBF, 8'hBF, 8'hFF, 8'h7F, 8'h7F, 8'hFF,
                 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD};

    b1.req = 1'b0; b1.sel = '0; b1.len = '0; b1.scan = 1'b0;
    b4.req = 1'b0; b4.sel = '0; b4.len = '0; b4.scan = 1'b0;

    // Reset held with req high
    rst_n = 1'b0;
    applyStimulus(1'b1, 3'd5, 4'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("reset", 8'hFF, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    tick();
    checkOutput("idle", 8'hFF, 1'b0, 1'b0);

    // Single strobe on line 5 for 3 cycles
    applyStimulus(1'b1, 3'd5, 4'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    checkOutput("strobe_d1", 8'hDF, 1'b1, 1'b0);
    tick();
    checkOutput("strobe_d2", 8'hDF, 1'b1, 1'b0);
    tick();
    checkOutput("strobe_d3", 8'hDF, 1'b1, 1'b0);
    tick();
    checkOutput("strobe_done", 8'hFF, 1'b0, 1'b1);
    tick();
    checkOutput("strobe_after", 8'hFF, 1'b0, 1'b0);

    // len=0 dwells one cycle; req held gives period 2
    applyStimulus(1'b1, 3'd0, 4'd0, 1'b0);
    tick();
    checkOutput("len0_a", 8'hFE, 1'b1, 1'b0);
    tick();
    checkOutput("len0_done_a", 8'hFF, 1'b0, 1'b1);
    tick();
    checkOutput("len0_b", 8'hFE, 1'b1, 1'b0);
    tick();
    checkOutput("len0_done_b", 8'hFF, 1'b0, 1'b1);
    tick();
    checkOutput("len0_c", 8'hFE, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    tick();
    checkOutput("len0_done_c", 8'hFF, 1'b0, 1'b1);
    tick();
    checkOutput("len0_idle", 8'hFF, 1'b0, 1'b0);

    // Scan from line 6 with one gap cycle, wrapping through 7 -> 0 -> 1
    applyStimulus(1'b1, 3'd6, 4'd2, 1'b1);
    for (int i = 0; i < 11; i++) begin
      tick();
      checkOutput($sformatf("scan_%0d", i), scan_exp[i], 1'b1, 1'b0);
      if (i == 9) applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    end
    tick();
    checkOutput("scan_done", 8'hFF, 1'b0, 1'b1);
    tick();
    checkOutput("scan_idle", 8'hFF, 1'b0, 1'b0);

    // Reset during a long dwell aborts without a done pulse
    applyStimulus(1'b1, 3'd2, 4'd15, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      checkOutput($sformatf("long_%0d", i + 1), 8'hFB, 1'b1, 1'b0);
    end
    rst_n = 1'b0;
    tick();
    checkOutput("abort", 8'hFF, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput("abort_quiet", 8'hFF, 1'b0, 1'b0);
    end

    // SEL_W=1 gapless scan from line 1
    b1.req = 1'b1; b1.sel = 1'b1; b1.len = 4'd1; b1.scan = 1'b1;
    tick();
    checkVal("d1_l1", 16'(b1.out_n), 16'h0001);
    tick();
    checkVal("d1_l0", 16'(b1.out_n), 16'h0002);
    tick();
    checkVal("d1_l1b", 16'(b1.out_n), 16'h0001);
    b1.req = 1'b0;
    tick();
    checkVal("d1_end_out",  16'(b1.out_n), 16'h0003);
    checkVal("d1_end_done", 16'(b1.done),  16'h0001);
    checkVal("d1_end_busy", 16'(b1.busy),  16'h0000);
    tick();
    checkVal("d1_idle_done", 16'(b1.done), 16'h0000);

    // SEL_W=4 gapless scan from line 15, two cycles per line
    b4.req = 1'b1; b4.sel = 4'd15; b4.len = 4'd2; b4.scan = 1'b1;
    tick();
    checkVal("d4_l15a", b4.out_n, 16'h7FFF);
    tick();
    checkVal("d4_l15b", b4.out_n, 16'h7FFF);
    tick();
    checkVal("d4_l0a", b4.out_n, 16'hFFFE);
    tick();
    checkVal("d4_l0b", b4.out_n, 16'hFFFE);
    tick();
    checkVal("d4_l1a", b4.out_n, 16'hFFFD);
    b4.req = 1'b0;
    tick();
    checkVal("d4_l1b", b4.out_n, 16'hFFFD);
    checkVal("d4_busy", 16'(b4.busy), 16'h0001);
    tick();
    checkVal("d4_end_out",  b4.out_n,      16'hFFFF);
    checkVal("d4_end_done", 16'(b4.done),  16'h0001);
    checkVal("d4_end_busy", 16'(b4.busy),  16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
